// File: rtl/b04_win_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : b04_win_arb_if
// Purpose  : Bundles the two requester channels, the b04 datapath drive
//            signals and the window status outputs of b04_win_arb.
// Ports    : (interface signals)
//            req0/req1     requester i offers a sample this cycle
//            data0/data1   requester i sample, two's complement, 8 bits
//            avg0/avg1     requester i wants datapath AVERAGE mode
//            ack0/ack1     sample on data_i accepted this cycle
//            dp_enable     datapath ENABLE
//            dp_average    datapath AVERAGE
//            dp_data       datapath DATA_IN, 8 bits
//            dp_restart    datapath RESTART, one-cycle pulse
//            win_done      window closed, one-cycle pulse
//            busy          a window is currently owned
//            owner         current or last owner index
//            sample_cnt    samples accepted in the current window, 8 bits
// Modports : master - requester / datapath side (drives req/data/avg)
//            slave  - arbiter side (drives ack, dp_* and status)
// Revision : 1.0 - initial release
// ============================================================================
interface b04_win_arb_if;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       avg0;
    logic       avg1;
    logic       ack0;
    logic       ack1;
    logic       dp_enable;
    logic       dp_average;
    logic [7:0] dp_data;
    logic       dp_restart;
    logic       win_done;
    logic       busy;
    logic       owner;
    logic [7:0] sample_cnt;

    modport master (
        output req0, req1, data0, data1, avg0, avg1,
        input  ack0, ack1, dp_enable, dp_average, dp_data, dp_restart,
        input  win_done, busy, owner, sample_cnt
    );

    modport slave (
        input  req0, req1, data0, data1, avg0, avg1,
        output ack0, ack1, dp_enable, dp_average, dp_data, dp_restart,
        output win_done, busy, owner, sample_cnt
    );
endinterface
`default_nettype wire

// File: rtl/b04_win_arb.sv
`default_nettype none
// ============================================================================
// Module   : b04_win_arb
// Purpose  : Two-requester window arbiter and sequencer in front of one b04
//            min/max/average datapath. One requester owns the datapath for a
//            whole window of WINDOW samples; the window is closed with a
//            one-cycle RESTART, then ownership is re-arbitrated round-robin.
// Params   : WINDOW   samples per window (2..255)
//            INIT_CYC warm-up cycles after reset before any grant (1..15)
//            IDLE_TO  consecutive owner-idle cycles that close a window (1..255)
// Ports    : clk    clock, all state changes on the rising edge
//            rst_n  asynchronous active-low reset
//            bus    b04_win_arb_if.slave - requester channels, datapath drive
//                   (dp_enable/dp_average/dp_data/dp_restart, registered),
//                   ack0/ack1 (combinational), win_done, busy, owner,
//                   sample_cnt
// Revision : 1.0 - initial release
// ============================================================================
module b04_win_arb #(
    parameter int WINDOW   = 16,
    parameter int INIT_CYC = 2,
    parameter int IDLE_TO  = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    b04_win_arb_if.slave     bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_warm  = 2'd0;
    localparam logic [1:0] c_st_idle  = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_flush = 2'd3;

    localparam logic [7:0] c_window   = 8'(WINDOW);
    localparam logic [7:0] c_idle_to  = 8'(IDLE_TO);
    localparam logic [3:0] c_init_cyc = 4'(INIT_CYC);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [3:0] r_warm_cnt;
    logic [7:0] r_idle_cnt;
    logic [7:0] r_sample_cnt;
    logic       r_owner;
    logic       r_last;
    logic       r_dp_enable;
    logic       r_dp_average;
    logic [7:0] r_dp_data;
    logic       r_dp_restart;
    logic       r_win_done;

    // ------------------------------------------------------------------------
    // Owner-side selection and accept decision
    // ------------------------------------------------------------------------
    logic       w_own_req;
    logic [7:0] w_own_data;
    logic       w_own_avg;
    logic       w_accept;
    logic       w_grant_any;
    logic       w_grant_idx;
    logic [7:0] w_cnt_inc;
    logic [7:0] w_idle_inc;
    logic       w_window_full;
    logic       w_timeout;

    assign w_own_req  = r_owner ? bus.req1  : bus.req0;
    assign w_own_data = r_owner ? bus.data1 : bus.data0;
    assign w_own_avg  = r_owner ? bus.avg1  : bus.avg0;

    // Samples are only taken while a window is locked; the non-owner is
    // never acknowledged, so it simply holds its request until re-arbitration.
    assign w_accept   = (r_state == c_st_run) && w_own_req;

    // Round-robin: on a tie the requester that did not win last time gets it.
    // r_last resets to 1 so requester 0 wins the very first tie.
    assign w_grant_any = bus.req0 | bus.req1;
    assign w_grant_idx = (bus.req0 && bus.req1) ? ~r_last : bus.req1;

    // Both counters are cleared whenever a window opens or closes and both
    // limits fit in 8 bits, so these increments never wrap.
    assign w_cnt_inc     = r_sample_cnt + 8'd1;
    assign w_idle_inc    = r_idle_cnt + 8'd1;
    assign w_window_full = (w_cnt_inc == c_window);
    assign w_timeout     = (w_idle_inc == c_idle_to);

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    // The dp_* outputs are registered, so every action decided in a state is
    // seen by the datapath one cycle later. In particular the FLUSH cycle
    // carries the enable of the final sample, and the restart it schedules
    // lands in the following cycle, after that sample has been absorbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_warm;
            r_warm_cnt   <= 4'd0;
            r_idle_cnt   <= 8'd0;
            r_sample_cnt <= 8'd0;
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            r_dp_enable  <= 1'b0;
            r_dp_average <= 1'b0;
            r_dp_data    <= 8'd0;
            r_dp_restart <= 1'b0;
            r_win_done   <= 1'b0;
        end else begin
            // Restart and window-done are single-cycle pulses by default.
            r_dp_restart <= 1'b0;
            r_win_done   <= 1'b0;

            case (r_state)
                c_st_warm: begin
                    // Give the datapath time for its own init sequence.
                    r_dp_enable <= 1'b0;
                    if (r_warm_cnt == c_init_cyc) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 4'd1;
                    end
                end

                c_st_idle: begin
                    r_dp_enable <= 1'b0;
                    if (w_grant_any) begin
                        r_owner      <= w_grant_idx;
                        r_last       <= w_grant_idx;
                        r_sample_cnt <= 8'd0;
                        r_idle_cnt   <= 8'd0;
                        r_state      <= c_st_run;
                    end
                end

                c_st_run: begin
                    if (w_own_req) begin
                        // Accepted sample: forward it and restart the idle
                        // count. A full window wins over any timeout.
                        r_dp_enable  <= 1'b1;
                        r_dp_data    <= w_own_data;
                        r_dp_average <= w_own_avg;
                        r_sample_cnt <= w_cnt_inc;
                        r_idle_cnt   <= 8'd0;
                        if (w_window_full) begin
                            r_state <= c_st_flush;
                        end
                    end else begin
                        // Owner stalled: data/average hold their last value.
                        r_dp_enable <= 1'b0;
                        r_idle_cnt  <= w_idle_inc;
                        if (w_timeout) begin
                            if (r_sample_cnt != 8'd0) begin
                                r_state <= c_st_flush;
                            end else begin
                                // Nothing reached the datapath, so there is
                                // nothing to restart; drop straight back.
                                r_idle_cnt <= 8'd0;
                                r_state    <= c_st_idle;
                            end
                        end
                    end
                end

                c_st_flush: begin
                    r_dp_enable  <= 1'b0;
                    r_dp_restart <= 1'b1;
                    r_win_done   <= 1'b1;
                    r_sample_cnt <= 8'd0;
                    r_idle_cnt   <= 8'd0;
                    r_state      <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_warm;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.ack0       = w_accept & ~r_owner;
    assign bus.ack1       = w_accept &  r_owner;
    assign bus.dp_enable  = r_dp_enable;
    assign bus.dp_average = r_dp_average;
    assign bus.dp_data    = r_dp_data;
    assign bus.dp_restart = r_dp_restart;
    assign bus.win_done   = r_win_done;
    assign bus.busy       = (r_state == c_st_run) || (r_state == c_st_flush);
    assign bus.owner      = r_owner;
    assign bus.sample_cnt = r_sample_cnt;

endmodule
`default_nettype wire
